eth_tx: RTL and testbench

ETH_TX -- requirements
Module: eth_tx

---
 rtl/eth_pkg.sv | 23 ++
 rtl/eth_tx.sv | 174 +++++++++++++++++
 tb/tb_eth_tx.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the reflected CRC-32 byte step,
// used by both the transmitter and the matching receiver.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [3:0]  PREAMBLE_LEN  = 4'd7;
    localparam logic [3:0]  HDR_LEN       = 4'd14;
    localparam logic [3:0]  IFG_LEN       = 4'd12;

    // Byte enters at the LSBs; one right shift per bit.
    function automatic logic [31:0] crc32_lsbf(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx.sv
// Byte-wide Ethernet frame transmitter: preamble, SFD, fixed header, length-framed payload, FCS.
// Build option: define ETH_TX_IFG_EN to insert a 12-cycle inter-frame gap state after the FCS.
//
//   state    | meaning
//   IDLE     | waiting for payload_valid; nothing consumed
//   PREAMBLE | 7 x 0x55
//   SFD      | 0xD5, CRC seeded
//   HEADER   | DST_MAC, SRC_MAC, ETHERTYPE, MSB first, folded into CRC
//   PAYLD    | pass-through of payload bytes until len+2 have been taken
//   FCS      | ~crc, least significant byte first
//   IFG      | silent gap before returning to IDLE
module eth_tx #(
    parameter logic [47:0] DST_MAC   = 48'h00_11_22_33_44_55,
    parameter logic [47:0] SRC_MAC   = 48'h00_AA_BB_CC_DD_EE,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  payload_byte,
    input  logic        payload_valid,
    output logic        payload_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    output logic        frame_done,
    output logic        busy,
    output logic [31:0] dbg_crc
);
    import eth_pkg::*;

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, HEADER, PAYLD, FCS, IFG} state_t;

    localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] pay_cnt_q, pay_cnt_d;
    logic [15:0] len_q, len_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_valid_q, tx_valid_d;
    logic        frame_done_q, frame_done_d;
    logic [31:0] dbg_crc_q, dbg_crc_d;

    logic        hs;
    logic        cnt_tc;
    logic        pay_last;
    logic [15:0] len_cur;
    logic [31:0] fcs_word;
    logic [1:0]  fcs_sel;
    logic [7:0]  hdr_byte;
    logic [7:0]  fcs_byte;

    assign hs       = payload_valid && (state_q == PAYLD);
    assign cnt_tc   = (cnt_q == 4'd0);
    // The low length byte is arriving on this very handshake when index 1 is taken.
    assign len_cur  = (pay_cnt_q == 17'd1) ? {len_q[15:8], payload_byte} : len_q;
    assign pay_last = hs && (pay_cnt_q != 17'd0) && (pay_cnt_q == ({1'b0, len_cur} + 17'd1));
    assign fcs_word = ~crc_q;
    assign fcs_sel  = 2'd3 - cnt_q[1:0];
    assign hdr_byte = HDR[{cnt_q, 3'b000} +: 8];
    assign fcs_byte = fcs_word[{fcs_sel, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            pay_cnt_q    <= 17'd0;
            len_q        <= 16'd0;
            crc_q        <= CRC32_INIT;
            tx_byte_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            dbg_crc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pay_cnt_q    <= pay_cnt_d;
            len_q        <= len_d;
            crc_q        <= crc_d;
            tx_byte_q    <= tx_byte_d;
            tx_valid_q   <= tx_valid_d;
            frame_done_q <= frame_done_d;
            dbg_crc_q    <= dbg_crc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (payload_valid) state_d = PREAMBLE;
            PREAMBLE: if (cnt_tc) state_d = SFD;
            SFD:      state_d = HEADER;
            HEADER:   if (cnt_tc) state_d = PAYLD;
            PAYLD:    if (pay_last) state_d = FCS;
`ifdef ETH_TX_IFG_EN
            FCS:      if (cnt_tc) state_d = IFG;
`else
            FCS:      if (cnt_tc) state_d = IDLE;
`endif
            IFG:      if (cnt_tc) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        pay_cnt_d    = pay_cnt_q;
        len_d        = len_q;
        crc_d        = crc_q;
        tx_byte_d    = tx_byte_q;
        tx_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        dbg_crc_d    = dbg_crc_q;
        case (state_q)
            IDLE: begin
                if (payload_valid) cnt_d = PREAMBLE_LEN - 4'd1;
            end
            PREAMBLE: begin
                tx_byte_d  = PREAMBLE_BYTE;
                tx_valid_d = 1'b1;
                if (!cnt_tc) cnt_d = cnt_q - 4'd1;
            end
            SFD: begin
                tx_byte_d  = SFD_BYTE;
                tx_valid_d = 1'b1;
                crc_d      = CRC32_INIT;
                cnt_d      = HDR_LEN - 4'd1;
            end
            HEADER: begin
                tx_byte_d  = hdr_byte;
                tx_valid_d = 1'b1;
                crc_d      = crc32_lsbf(crc_q, hdr_byte);
                if (cnt_tc) pay_cnt_d = 17'd0;
                else        cnt_d     = cnt_q - 4'd1;
            end
            PAYLD: begin
                if (hs) begin
                    tx_byte_d  = payload_byte;
                    tx_valid_d = 1'b1;
                    crc_d      = crc32_lsbf(crc_q, payload_byte);
                    pay_cnt_d  = pay_cnt_q + 17'd1;
                    if (pay_cnt_q == 17'd0) len_d[15:8] = payload_byte;
                    if (pay_cnt_q == 17'd1) len_d[7:0]  = payload_byte;
                    if (pay_last) cnt_d = 4'd3;
                end
            end
            FCS: begin
                tx_byte_d  = fcs_byte;
                tx_valid_d = 1'b1;
                if (cnt_tc) begin
                    frame_done_d = 1'b1;
                    dbg_crc_d    = fcs_word;
`ifdef ETH_TX_IFG_EN
                    cnt_d        = IFG_LEN - 4'd1;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            IFG: begin
                if (!cnt_tc) cnt_d = cnt_q - 4'd1;
            end
            default: ;
        endcase
    end

    assign payload_ready = (state_q == PAYLD);
    assign busy          = (state_q != IDLE);
    assign tx_byte       = tx_byte_q;
    assign tx_valid      = tx_valid_q;
    assign frame_done    = frame_done_q;
    assign dbg_crc       = dbg_crc_q;

endmodule

// File: tb/tb_eth_tx.sv
// Directed-plus-random bench for eth_tx: an ideal frame builder and a CRC residue receiver
// judge every captured frame; reset abort and inter-frame spacing are checked directly.
module tb_eth_tx;

    typedef logic [7:0] byte_t;
    typedef byte_t bq_t[$];

    localparam logic [47:0] DST = 48'h00_11_22_33_44_55;
    localparam logic [47:0] SRC = 48'h00_AA_BB_CC_DD_EE;
    localparam logic [15:0] ET  = 16'h88B5;
`ifdef ETH_TX_IFG_EN
    localparam int EXP_GAP = 13;
`else
    localparam int EXP_GAP = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  payload_byte;
    logic        payload_valid;
    logic        payload_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        frame_done;
    logic        busy;
    logic [31:0] dbg_crc;

    eth_tx #(.DST_MAC(DST), .SRC_MAC(SRC), .ETHERTYPE(ET)) dut (
        .clk(clk), .rst_n(rst_n),
        .payload_byte(payload_byte), .payload_valid(payload_valid), .payload_ready(payload_ready),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .frame_done(frame_done),
        .busy(busy), .dbg_crc(dbg_crc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Wire-side capture: every valid byte, the idle run preceding it, and where frame_done fell.
    byte_t rx[$];
    int    gap_q[$];
    int    done_idx[$];
    int    done_cnt = 0;
    int    gap_run  = 0;

    always @(negedge clk) begin
        if (tx_valid === 1'b1) begin
            rx.push_back(tx_byte);
            gap_q.push_back(gap_run);
            gap_run = 0;
        end else begin
            gap_run++;
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_idx.push_back(rx.size() - 1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit-serial reflected CRC register, no final inversion.
    function automatic logic [31:0] crc_ref(input bq_t q);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    function automatic bq_t frame_body(input bq_t pl);
        bq_t          body;
        logic [111:0] h;
        h = {DST, SRC, ET};
        for (int i = 0; i < 14; i++) body.push_back(h[111 - 8*i -: 8]);
        foreach (pl[i]) body.push_back(pl[i]);
        return body;
    endfunction

    function automatic bq_t build_frame(input bq_t pl);
        bq_t         f;
        bq_t         body;
        logic [31:0] fcs;
        body = frame_body(pl);
        fcs  = ~crc_ref(body);
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        foreach (body[i]) f.push_back(body[i]);
        for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
        return f;
    endfunction

    function automatic bq_t mk_payload(input int len);
        bq_t         q;
        logic [15:0] l;
        l = len[15:0];
        q.push_back(l[15:8]);
        q.push_back(l[7:0]);
        for (int i = 0; i < len; i++) q.push_back(byte_t'($urandom_range(0, 255)));
        return q;
    endfunction

    task automatic send(input bq_t pl, input int stall_after, input int stall_len, input bit hold);
        for (int i = 0; i < pl.size(); i++) begin
            int n;
            bit hs;
            payload_valid = 1'b1;
            payload_byte  = pl[i];
            n = 0;
            do begin
                hs = payload_ready;
                @(posedge clk);
                #1;
                n++;
            end while (!hs && n < 3000);
            chk("handshake", 32'(hs), 32'd1);
            if (!hs) return;
            if (i == stall_after) begin
                payload_valid = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
        end
        if (!hold) payload_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_wait", 32'(done_cnt >= target), 32'd1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int off, input bq_t pl,
                               input int gap_pos, input int gap_len, input bit is_last);
        bq_t ef;
        bq_t rxb;
        int  n;
        int  nerr = 0;
        int  gerr = 0;
        int  dn   = 0;
        int  eg;
        ef = build_frame(pl);
        n  = ef.size();
        for (int i = 0; i < n; i++) begin
            if (off + i >= rx.size() || rx[off + i] !== ef[i]) nerr++;
        end
        chk({tag, "_bytes"}, 32'(nerr), 32'd0);
        for (int i = 1; i < n; i++) begin
            eg = (i == gap_pos) ? gap_len : 0;
            if (off + i >= gap_q.size() || gap_q[off + i] != eg) gerr++;
        end
        chk({tag, "_gaps"}, 32'(gerr), 32'd0);
        foreach (done_idx[i]) if (done_idx[i] >= off && done_idx[i] < off + n) dn++;
        chk({tag, "_done_cnt"}, 32'(dn), 32'd1);
        dn = 0;
        foreach (done_idx[i]) if (done_idx[i] == off + n - 1) dn++;
        chk({tag, "_done_pos"}, 32'(dn), 32'd1);
        for (int i = 8; i < n && off + i < rx.size(); i++) rxb.push_back(rx[off + i]);
        chk({tag, "_crc_ok"}, crc_ref(rxb), 32'hDEBB20E3);
        if (is_last) begin
            chk({tag, "_len"}, 32'(rx.size() - off), 32'(n));
            chk({tag, "_dbg_crc"}, dbg_crc, ~crc_ref(frame_body(pl)));
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        bq_t pa, pb, pc, pd, p1, p2, pe;
        int  base, d0, n, l1;

        rst_n = 1'b0;
        payload_valid = 1'b0;
        payload_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dbg_crc", dbg_crc, 32'd0);
        chk("rst_ready", 32'(payload_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame A: the reference 3-byte ITCH message.
        pa = {8'h00, 8'h03, 8'h41, 8'h42, 8'h43};
        base = rx.size();
        d0 = done_cnt;
        payload_valid = 1'b1;
        payload_byte = pa[0];
        chk("idle_no_ready", 32'(payload_ready), 32'd0);
        send(pa, -1, 0, 1'b0);
        wait_done(d0 + 1);
        check_frame("A", base, pa, -1, 0, 1'b1);
        chk("A_total_31", 32'(rx.size() - base), 32'd31);
        chk("A_idle_busy", 32'(busy), 32'd0);

        // Frame B: zero length, FCS right after the two length bytes.
        pb = {8'h00, 8'h00};
        base = rx.size();
        d0 = done_cnt;
        send(pb, -1, 0, 1'b0);
        wait_done(d0 + 1);
        check_frame("B", base, pb, -1, 0, 1'b1);

        // Frame C: random body, source stalls 3 cycles after payload byte 3.
        pc = mk_payload($urandom_range(4, 10));
        base = rx.size();
        d0 = done_cnt;
        send(pc, 3, 3, 1'b0);
        wait_done(d0 + 1);
        check_frame("C", base, pc, 8 + 14 + 4, 3, 1'b1);

        // Abort: reset for one edge while header byte 5 is being produced.
        base = rx.size();
        d0 = done_cnt;
        payload_valid = 1'b1;
        payload_byte = 8'h00;
        n = 0;
        while (rx.size() < base + 13 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_reach", 32'(rx.size() - base), 32'd13);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_ready_hdr", 32'(payload_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        payload_valid = 1'b0;
        chk("abort_tx_valid", 32'(tx_valid), 32'd0);
        chk("abort_busy_low", 32'(busy), 32'd0);
        chk("abort_dbg_crc", dbg_crc, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        chk("abort_no_bytes", 32'(rx.size() - base), 32'd13);

        // Frame D: normal frame after the abort.
        pd = mk_payload($urandom_range(0, 12));
        base = rx.size();
        d0 = done_cnt;
        send(pd, -1, 0, 1'b0);
        wait_done(d0 + 1);
        check_frame("D", base, pd, -1, 0, 1'b1);

        // Back-to-back with payload_valid never dropping.
        p1 = mk_payload($urandom_range(0, 6));
        p2 = mk_payload($urandom_range(0, 6));
        l1 = p1.size() + 26;
        base = rx.size();
        d0 = done_cnt;
        send(p1, -1, 0, 1'b1);
        send(p2, -1, 0, 1'b0);
        wait_done(d0 + 2);
        check_frame("B2B1", base, p1, -1, 0, 1'b0);
        check_frame("B2B2", base + l1, p2, -1, 0, 1'b1);
        chk("b2b_gap", 32'(gap_q[base + l1]), 32'(EXP_GAP));

        // Long frame: len 0x0100.
        pe = mk_payload(256);
        base = rx.size();
        d0 = done_cnt;
        send(pe, -1, 0, 1'b0);
        wait_done(d0 + 1);
        check_frame("E", base, pe, -1, 0, 1'b1);
        chk("E_total_284", 32'(rx.size() - base), 32'd284);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
